// File: rtl/inst_mem_model.sv
// Instruction-memory responder for the MIPS32 fetch port: preloadable word store,
// programmable wait states per fetch, one-cycle ack pulse, fetch counter and range flag.
module inst_mem_model #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 30,
    parameter int DEPTH      = 1024,
    parameter int LATENCY    = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [ADDR_WIDTH-1:0]    InstMem_Address,
    input  logic                     InstMem_Read,
    output logic [DATA_WIDTH-1:0]    InstMem_In,
    output logic                     InstMem_Ack,
    input  logic                     Load_En,
    input  logic [$clog2(DEPTH)-1:0] Load_Addr,
    input  logic [DATA_WIDTH-1:0]    Load_Data,
    input  logic [3:0]               Extra_Wait,
    output logic [31:0]              Fetch_Count,
    output logic                     Range_Error,
    output logic [1:0]               debug_state
);
    localparam int IW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t                  state, state_n;
    logic [4:0]              cnt, cnt_n;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_n;
    logic [ADDR_WIDTH-1:0]   fire_addr;
    logic                    fire;
    logic                    fire_in_range;
    logic [4:0]              wait_total;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    // Request handshake: the core raises InstMem_Read with a stable word address
    // and holds it until InstMem_Ack pulses; dropping it during the wait aborts.
    assign wait_total    = 5'(LATENCY) + {1'b0, Extra_Wait};
    assign fire_in_range = 64'(fire_addr) < 64'(DEPTH);
    assign debug_state   = state;

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            addr_q <= '0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            addr_q <= addr_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        addr_n    = addr_q;
        fire      = 1'b0;
        fire_addr = addr_q;
        unique case (state)
            S_IDLE: begin
                if (InstMem_Read) begin
                    addr_n = InstMem_Address;
                    if (wait_total == 5'd0) begin
                        // Zero wait states: the read happens on the accepting edge.
                        state_n   = S_ACK;
                        fire      = 1'b1;
                        fire_addr = InstMem_Address;
                    end else begin
                        state_n = S_WAIT;
                        cnt_n   = wait_total;
                    end
                end
            end
            S_WAIT: begin
                if (!InstMem_Read) begin
                    state_n = S_IDLE;
                end else begin
                    cnt_n = cnt - 5'd1;
                    if (cnt == 5'd1) begin
                        state_n = S_ACK;
                        fire    = 1'b1;
                    end
                end
            end
            S_ACK:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Loads ignore reset so boot contents can be written while the core is held.
    always_ff @(posedge clock) begin
        if (Load_En) begin
            mem[Load_Addr] <= Load_Data;
        end
    end

    // Reads mem before the same-edge load lands, giving read-before-write.
    always_ff @(posedge clock) begin
        if (reset) begin
            InstMem_Ack <= 1'b0;
            InstMem_In  <= '0;
            Fetch_Count <= '0;
            Range_Error <= 1'b0;
        end else begin
            InstMem_Ack <= fire;
            InstMem_In  <= '0;
            if (fire) begin
                Fetch_Count <= Fetch_Count + 32'd1;
                if (fire_in_range) begin
                    InstMem_In <= mem[fire_addr[IW-1:0]];
                end else begin
                    Range_Error <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_inst_mem_model.sv
// Bench for inst_mem_model: directed fetch scenarios followed by randomized
// fetches, aborts and loads, checked every cycle against a transaction-level model.
module tb_inst_mem_model;
    localparam int LAT   = 1;
    localparam int DEPTH = 1024;

    logic        clock = 1'b0;
    logic        reset;
    logic [29:0] InstMem_Address;
    logic        InstMem_Read;
    logic [31:0] InstMem_In;
    logic        InstMem_Ack;
    logic        Load_En;
    logic [9:0]  Load_Addr;
    logic [31:0] Load_Data;
    logic [3:0]  Extra_Wait;
    logic [31:0] Fetch_Count;
    logic        Range_Error;
    logic [1:0]  debug_state;

    inst_mem_model #(.DATA_WIDTH(32), .ADDR_WIDTH(30), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clock(clock), .reset(reset),
        .InstMem_Address(InstMem_Address), .InstMem_Read(InstMem_Read),
        .InstMem_In(InstMem_In), .InstMem_Ack(InstMem_Ack),
        .Load_En(Load_En), .Load_Addr(Load_Addr), .Load_Data(Load_Data),
        .Extra_Wait(Extra_Wait), .Fetch_Count(Fetch_Count),
        .Range_Error(Range_Error), .debug_state(debug_state)
    );

    // ---------------- clock / edge index ----------------
    always #5 clock = ~clock;
    int edge_cnt = 0;
    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    // ---------------- model state / scoreboard ----------------
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] mem_m [16];
    int          edge_q [$];
    logic [31:0] exp_q  [$];
    bit          oor_q  [$];
    logic [31:0] m_count = 0;
    bit          m_range = 0;
    int          dut_ack_edge = -1;
    logic [31:0] dut_ack_data = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare, 1 time unit after each rising edge.
    always begin
        int          k;
        bit          e_ack;
        logic [31:0] e_data;
        @(posedge clock);
        #1;
        k      = edge_cnt;
        e_ack  = 1'b0;
        e_data = 32'h0;
        if (reset) begin
            edge_q.delete(); exp_q.delete(); oor_q.delete();
            m_count = 0;
            m_range = 0;
        end else if (edge_q.size() > 0 && edge_q[0] == k) begin
            void'(edge_q.pop_front());
            e_data  = exp_q.pop_front();
            m_range = m_range | oor_q.pop_front();
            m_count = m_count + 1;
            e_ack   = 1'b1;
        end
        if (InstMem_Ack === 1'b1) begin
            dut_ack_edge = k;
            dut_ack_data = InstMem_In;
        end
        chk("ack", {31'b0, InstMem_Ack}, {31'b0, e_ack});
        chk("data", InstMem_In, e_data);
        chk("count", Fetch_Count, m_count);
        chk("range", {31'b0, Range_Error}, {31'b0, m_range});
    end

    // ---------------- driver tasks ----------------
    task automatic load(input logic [3:0] a, input logic [31:0] d);
        Load_En = 1'b1; Load_Addr = {6'b0, a}; Load_Data = d;
        @(negedge clock);
        Load_En = 1'b0;
        mem_m[a] = d;
    endtask

    // Full fetch: request held through the wait, optional same-edge load on the
    // ack edge, garbage on the address/Extra_Wait lines once the request is taken.
    task automatic fetch(input logic [29:0] a, input logic [3:0] ew, input bit ld_same,
                         input logic [31:0] ld_data, output int e0);
        int w;
        w  = LAT + int'(ew);
        e0 = edge_cnt + 1;
        InstMem_Read = 1'b1; InstMem_Address = a; Extra_Wait = ew;
        for (int i = 0; i < w; i++) begin
            @(negedge clock);
            InstMem_Address = 30'($urandom);
            Extra_Wait      = 4'($urandom);
        end
        edge_q.push_back(e0 + w);
        exp_q.push_back((a < 30'(DEPTH)) ? mem_m[a[3:0]] : 32'h0);
        oor_q.push_back(a >= 30'(DEPTH));
        if (ld_same) begin
            Load_En = 1'b1; Load_Addr = a[9:0]; Load_Data = ld_data;
        end
        @(negedge clock);
        if (ld_same) begin
            Load_En = 1'b0;
            mem_m[a[3:0]] = ld_data;
        end
        InstMem_Read    = 1'($urandom_range(0, 1));
        InstMem_Address = 30'($urandom);
        @(negedge clock);
        InstMem_Read = 1'b0;
        Extra_Wait   = 4'd0;
    endtask

    task automatic abort_fetch(input logic [29:0] a, input logic [3:0] ew, input int k);
        InstMem_Read = 1'b1; InstMem_Address = a; Extra_Wait = ew;
        repeat (k) @(negedge clock);
        InstMem_Read = 1'b0;
        @(negedge clock);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int e0;
        int prev_ack;
        reset = 1'b1; InstMem_Read = 1'b0; InstMem_Address = '0;
        Load_En = 1'b0; Load_Addr = '0; Load_Data = '0; Extra_Wait = '0;
        @(negedge clock);
        load(4'd0, 32'h20080001);
        load(4'd1, 32'h20090002);
        load(4'd2, 32'h01095020);
        load(4'd3, 32'h00000000);
        for (int i = 4; i < 16; i++) load(4'(i), $urandom);
        reset = 1'b0;
        @(negedge clock);

        fetch(30'd0, 4'd0, 1'b0, 32'h0, e0);
        chk("first_latency", 32'(dut_ack_edge - e0), 32'd1);
        chk("first_data", dut_ack_data, 32'h20080001);
        fetch(30'd1, 4'd0, 1'b0, 32'h0, e0);
        chk("seq1_data", dut_ack_data, 32'h20090002);
        fetch(30'd2, 4'd0, 1'b0, 32'h0, e0);
        chk("seq2_data", dut_ack_data, 32'h01095020);
        fetch(30'd3, 4'd0, 1'b0, 32'h0, e0);
        chk("seq3_data", dut_ack_data, 32'h00000000);
        chk("seq_count", Fetch_Count, 32'd4);

        fetch(30'd2, 4'd5, 1'b0, 32'h0, e0);
        chk("ew5_latency", 32'(dut_ack_edge - e0), 32'd6);
        chk("ew5_data", dut_ack_data, 32'h01095020);

        prev_ack = dut_ack_edge;
        abort_fetch(30'd3, 4'd2, 2);
        repeat (6) @(negedge clock);
        chk("abort_no_ack", 32'(dut_ack_edge), 32'(prev_ack));
        chk("abort_count", Fetch_Count, 32'd5);
        fetch(30'd1, 4'd0, 1'b0, 32'h0, e0);
        chk("post_abort_data", dut_ack_data, 32'h20090002);

        fetch(30'd1024, 4'd0, 1'b0, 32'h0, e0);
        chk("oor_data", dut_ack_data, 32'h0);
        chk("oor_flag", {31'b0, Range_Error}, 32'd1);
        fetch(30'd0, 4'd1, 1'b0, 32'h0, e0);
        chk("oor_sticky", {31'b0, Range_Error}, 32'd1);

        fetch(30'd1, 4'd0, 1'b1, 32'hDEADBEEF, e0);
        chk("rbw_old", dut_ack_data, 32'h20090002);
        fetch(30'd1, 4'd0, 1'b0, 32'h0, e0);
        chk("rbw_new", dut_ack_data, 32'hDEADBEEF);

        prev_ack = dut_ack_edge;
        InstMem_Read = 1'b1; InstMem_Address = 30'd3; Extra_Wait = 4'd4;
        repeat (2) @(negedge clock);
        reset = 1'b1; InstMem_Read = 1'b0;
        @(negedge clock);
        load(4'd7, 32'h12345678);
        chk("rst_ack", {31'b0, InstMem_Ack}, 32'd0);
        chk("rst_data", InstMem_In, 32'd0);
        chk("rst_count", Fetch_Count, 32'd0);
        chk("rst_range", {31'b0, Range_Error}, 32'd0);
        chk("rst_no_ack", 32'(dut_ack_edge), 32'(prev_ack));
        reset = 1'b0;
        @(negedge clock);
        fetch(30'd0, 4'd0, 1'b0, 32'h0, e0);
        chk("mem_kept", dut_ack_data, 32'h20080001);
        fetch(30'd7, 4'd2, 1'b0, 32'h0, e0);
        chk("load_in_reset", dut_ack_data, 32'h12345678);

        for (int n = 0; n < 80; n++) begin
            int          op;
            logic [29:0] a;
            logic [3:0]  ew;
            op = $urandom_range(0, 9);
            ew = 4'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) a = 30'(DEPTH + $urandom_range(0, 100000));
            else                           a = 30'($urandom_range(0, 15));
            if (op < 2) begin
                load(4'($urandom_range(0, 15)), $urandom);
            end else if (op == 2) begin
                abort_fetch(a, ew, $urandom_range(1, LAT + int'(ew)));
            end else begin
                fetch(a, ew, (a < 30'(DEPTH)) && ($urandom_range(0, 4) == 0), $urandom, e0);
            end
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end

        repeat (3) @(negedge clock);
        chk("queue_drained", 32'(edge_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
